// File: rtl/disp_pkg.sv
// Shared types and constants for the 4-digit multiplexed 7-segment display path.
package disp_pkg;

    localparam int unsigned NUM_DIGITS = 4;

    typedef logic [1:0]              digit_idx_t;
    typedef logic [4*NUM_DIGITS-1:0] disp_val_t;

    // Digit-select pattern that turns every digit off; used together with blank_out.
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = 4'b1111;

    function automatic logic [3:0] nibble_at(disp_val_t v, digit_idx_t d);
        return v[4*d +: 4];
    endfunction

endpackage

// File: rtl/disp_scan_ctrl_if.sv
// Valid/ready channel carrying a new 16-bit display value into the scan controller.
interface disp_scan_ctrl_if;
    import disp_pkg::*;

    disp_val_t val_in;
    logic      val_valid;
    logic      val_ready;

    modport master (output val_in, output val_valid, input val_ready);
    modport slave  (input val_in, input val_valid, output val_ready);

endinterface

// File: rtl/disp_prescaler.sv
// Free-running 0..TICK_DIV-1 counter; tc marks the last count before the wrap.
module disp_prescaler #(
    parameter int unsigned TICK_DIV = 100000,
    localparam int unsigned CNT_W   = $clog2(TICK_DIV)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    assign tc = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tc) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Digit scan controller: steps digits 0..3, swaps in new values only at frame boundaries
// and decodes blanking (guard band, per-digit enable, leading-zero suppression).
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 100000,
    parameter int unsigned GUARD_CYC = 2000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    disp_scan_ctrl_if.slave       val_if,
    input  logic                  blank_lz,
    input  logic [NUM_DIGITS-1:0] dig_en,
    output digit_idx_t            sel_out,
    output logic [3:0]            nib_out,
    output logic                  blank_out,
    output logic                  frame_tick
);

    localparam int unsigned CNT_W = $clog2(TICK_DIV);

    logic [CNT_W-1:0]      cnt;
    logic                  tc;
    digit_idx_t            digit_q, digit_d;
    disp_val_t             active_q, active_d;
    disp_val_t             pending_q, pending_d;
    logic                  pend_full_q, pend_full_d;
    logic                  frame_edge;
    logic                  xfer;
    logic [NUM_DIGITS-1:0] nz;
    logic                  upper_zero;
    logic                  lz_blank;
    logic                  guard;

    disp_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .cnt  (cnt),
        .tc   (tc)
    );

    assign frame_edge = tc && (digit_q == digit_idx_t'(NUM_DIGITS - 1));
    assign xfer       = val_if.val_valid && !pend_full_q;

    // A value accepted on a boundary cycle lands in pending only; it never bypasses to active.
    always_comb begin
        digit_d     = digit_q;
        active_d    = active_q;
        pending_d   = pending_q;
        pend_full_d = pend_full_q;
        if (tc) begin
            digit_d = digit_q + 2'd1;
        end
        if (frame_edge && pend_full_q) begin
            active_d    = pending_q;
            pend_full_d = 1'b0;
        end
        if (xfer) begin
            pending_d   = val_if.val_in;
            pend_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q     <= '0;
            active_q    <= '0;
            pending_q   <= '0;
            pend_full_q <= 1'b0;
        end else begin
            digit_q     <= digit_d;
            active_q    <= active_d;
            pending_q   <= pending_d;
            pend_full_q <= pend_full_d;
        end
    end

    always_comb begin
        nz = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            nz[i] = |active_q[4*i +: 4];
        end
    end

    // Leading zero: this nibble and every more-significant one are zero.
    assign upper_zero = ((nz >> digit_q) == '0);
    assign lz_blank   = blank_lz && (digit_q != '0) && upper_zero;
    assign guard      = 32'(cnt) < GUARD_CYC;

    assign sel_out          = digit_q;
    assign nib_out          = nibble_at(active_q, digit_q);
    assign blank_out        = guard || !dig_en[digit_q] || lz_blank;
    assign frame_tick       = frame_edge;
    assign val_if.val_ready = !pend_full_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Scoreboard bench for disp_scan_ctrl: a time-based reference model queues expected
// scan state per cycle and a negedge monitor compares the DUT against it.
module tb_disp_scan_ctrl;
    import disp_pkg::*;

    localparam int unsigned TICK_DIV  = 4;
    localparam int unsigned GUARD_CYC = 1;

    typedef struct {
        int        cnt;
        int        digit;
        logic [15:0] active;
        bit        ready;
    } snap_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       blank_lz;
    logic [3:0] dig_en;
    digit_idx_t sel_out;
    logic [3:0] nib_out;
    logic       blank_out;
    logic       frame_tick;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int          m_t = 0;
    logic [15:0] m_active = 16'h0;
    logic [15:0] m_pend[$];
    snap_t       exp_q[$];

    disp_scan_ctrl_if vif ();

    disp_scan_ctrl #(
        .TICK_DIV (TICK_DIV),
        .GUARD_CYC(GUARD_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .val_if    (vif.slave),
        .blank_lz  (blank_lz),
        .dig_en    (dig_en),
        .sel_out   (sel_out),
        .nib_out   (nib_out),
        .blank_out (blank_out),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: digit/cnt follow from elapsed cycles; values move pending->active at frame ends.
    bit          m_acc;
    logic [15:0] m_v;
    bit          m_bound;
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_t      = 0;
                m_active = 16'h0;
                m_pend.delete();
                exp_q.delete();
            end else begin
                m_acc   = vif.val_valid && (m_pend.size() == 0);
                m_v     = vif.val_in;
                m_bound = (m_t % TICK_DIV == TICK_DIV - 1) && ((m_t / TICK_DIV) % 4 == 3);
                if (m_bound && m_pend.size() > 0) m_active = m_pend.pop_front();
                if (m_acc) m_pend.push_back(m_v);
                m_t++;
                exp_q.push_back('{cnt: m_t % TICK_DIV, digit: (m_t / TICK_DIV) % 4,
                                  active: m_active, ready: (m_pend.size() == 0)});
            end
        end
    end

    snap_t s;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && exp_q.size() > 0) begin
                s = exp_q.pop_front();
                check("sel_out", int'(sel_out), s.digit);
                check("nib_out", int'(nib_out), int'((s.active >> (4 * s.digit)) & 16'hF));
                check("blank_out", int'(blank_out),
                      int'((s.cnt < GUARD_CYC) || !dig_en[s.digit] ||
                           (blank_lz && s.digit != 0 && (s.active >> (4 * s.digit)) == 16'h0)));
                check("val_ready", int'(vif.val_ready), int'(s.ready));
                check("frame_tick", int'(frame_tick),
                      int'(s.cnt == TICK_DIV - 1 && s.digit == 3));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] v);
        bit   done = 0;
        logic r;
        vif.val_in    = v;
        vif.val_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            r = vif.val_ready;
            @(posedge clk);
            #1;
            if (r) done = 1;
        end
        vif.val_valid = 1'b0;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL send_timeout: value %0h not accepted, required within 200 cycles", v);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sel"}, int'(sel_out), 0);
        check({tag, "_nib"}, int'(nib_out), 0);
        check({tag, "_ready"}, int'(vif.val_ready), 1);
        check({tag, "_tick"}, int'(frame_tick), 0);
        check({tag, "_blank"}, int'(blank_out), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        logic [15:0] mask;
        rst_n         = 1'b0;
        blank_lz      = 1'b0;
        dig_en        = 4'hF;
        vif.val_in    = 16'h0;
        vif.val_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        idle(40);

        // Frame-aligned update, issued mid-frame
        idle(5);
        send(16'h1234);
        idle(40);

        // Backpressure: second value held until the first is applied
        send(16'hAAAA);
        send(16'hBBBB);
        idle(40);

        // Leading-zero blanking
        blank_lz = 1'b1;
        send(16'h0050);
        idle(40);
        send(16'h0000);
        idle(40);
        blank_lz = 1'b0;

        // Per-digit enable mask
        send(16'h9876);
        dig_en = 4'b0101;
        idle(40);
        dig_en = 4'hF;

        // Randomized traffic and display controls
        for (int k = 0; k < 25; k++) begin
            case ($urandom_range(0, 3))
                0:       mask = 16'h000F;
                1:       mask = 16'h00FF;
                2:       mask = 16'h0FFF;
                default: mask = 16'hFFFF;
            endcase
            dig_en   = 4'($urandom_range(0, 15));
            blank_lz = 1'($urandom_range(0, 1));
            idle($urandom_range(0, 12));
            send(16'($urandom) & mask);
        end
        dig_en   = 4'hF;
        blank_lz = 1'b0;
        idle(20);

        // Reset in the middle of digit 2 while a value is pending
        send(16'hDEAD);
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (sel_out == 2'd2 && !vif.val_ready) found = 1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL midreset_wait: digit 2 with pending value not seen, required within 200 cycles");
        end
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
